// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM save-slot sequencer.
package bk_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StXfer = 2'd2
  } bk_state_e;

  typedef enum logic {
    OpSave = 1'b0,
    OpLoad = 1'b1
  } bk_op_e;

  localparam int unsigned SECTOR_BYTES = 512;

endpackage

// File: rtl/bk_ack_watchdog.sv
// Ack watchdog: counts while enabled, flags expiry on the cycle the count reaches all ones.
module bk_ack_watchdog #(
  parameter int unsigned TO_BITS = 24
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_BITS-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + TO_BITS'(1);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  // Abort lands on the same edge the counter reaches all ones.
  assign expire = en & ~clr & (&cnt_inc);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bk_slot_sequencer.sv
// Turns load/save menu requests into a run of whole-sector sd_rd/sd_wr requests for one slot.
module bk_slot_sequencer
  import bk_pkg::*;
#(
  parameter int unsigned     SLOT_BITS = 2,
  parameter int unsigned     SECT_BITS = 6,
  parameter int unsigned     LBA_W     = 32,
  parameter logic [LBA_W-1:0] LBA_BASE = '0,
  parameter int unsigned     TO_BITS   = 24
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  output logic [LBA_W-1:0]     sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic [SECT_BITS-1:0] sect,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 err
);

  bk_state_e state_q, state_d;
  bk_op_e    op_q, op_d;

  logic [LBA_W-1:0]     lba_q, lba_d, slot_lba;
  logic [SECT_BITS-1:0] sect_q, sect_d;
  logic rd_q, rd_d, wr_q, wr_d, done_q, done_d, err_q, err_d;

  // Inputs are registered first; edges are detected between the two stages.
  logic load_s, load_old, save_s, save_old, ack_s, ack_old;
  logic load_start, save_start, ack_rise, ack_fall;
  logic wd_clr, wd_en, wd_expire;

  assign load_start = load_s & ~load_old;
  assign save_start = save_s & ~save_old;
  assign ack_rise   = ack_s & ~ack_old;
  assign ack_fall   = ~ack_s & ack_old;
  assign slot_lba   = LBA_BASE + LBA_W'({slot, {SECT_BITS{1'b0}}});

  // Holding the counter clear in idle gives a zero count on every entry to REQ.
  assign wd_clr = (state_q == StIdle) | (ack_s ^ ack_old);
  assign wd_en  = (state_q != StIdle);

  bk_ack_watchdog #(
    .TO_BITS (TO_BITS)
  ) u_watchdog (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expire  (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lba_d   = lba_q;
    sect_d  = sect_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_start || save_start) begin
          op_d    = load_start ? OpLoad : OpSave;
          sect_d  = '0;
          lba_d   = slot_lba;
          rd_d    = load_start;
          wr_d    = ~load_start;
          state_d = StReq;
        end
      end
      StReq: begin
        if (wd_expire) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (ack_fall) begin
          if (&sect_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            sect_d  = sect_q + SECT_BITS'(1);
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = (op_q == OpLoad);
            wr_d    = (op_q == OpSave);
            state_d = StReq;
          end
        end
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_s   <= 1'b0;
      load_old <= 1'b0;
      save_s   <= 1'b0;
      save_old <= 1'b0;
      ack_s    <= 1'b0;
      ack_old  <= 1'b0;
      state_q  <= StIdle;
      op_q     <= OpSave;
      lba_q    <= LBA_BASE;
      sect_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      load_s   <= load_req & ena;
      load_old <= load_s;
      save_s   <= save_req & ena;
      save_old <= save_s;
      ack_s    <= sd_ack;
      ack_old  <= ack_s;
      state_q  <= state_d;
      op_q     <= op_d;
      lba_q    <= lba_d;
      sect_q   <= sect_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign sect    = sect_q;
  assign busy    = (state_q != StIdle);
  assign loading = (state_q != StIdle) & (op_q == OpLoad);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bk_slot_sequencer.sv
// Scoreboard bench: instance a uses defaults, instance b a small slot with a short watchdog.
module tb_bk_slot_sequencer;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  // Instance a: defaults (64 sectors per slot, base 0)
  logic        ena = 1'b1, load_req = 1'b0, save_req = 1'b0, sd_ack = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] sd_lba;
  logic [5:0]  sect;
  logic        sd_rd, sd_wr, busy, loading, done, err;

  // Instance b: 4 sectors per slot, base 1000, 15-cycle watchdog
  logic        ena_b = 1'b1, load_req_b = 1'b0, save_req_b = 1'b0, sd_ack_b = 1'b0;
  logic [1:0]  slot_b = 2'd0;
  logic [31:0] sd_lba_b;
  logic [1:0]  sect_b;
  logic        sd_rd_b, sd_wr_b, busy_b, loading_b, done_b, err_b;

  bk_slot_sequencer dut (
    .clk_sys (clk_sys), .reset (reset), .ena (ena), .load_req (load_req),
    .save_req (save_req), .slot (slot), .sd_lba (sd_lba), .sd_rd (sd_rd),
    .sd_wr (sd_wr), .sd_ack (sd_ack), .sect (sect), .busy (busy),
    .loading (loading), .done (done), .err (err)
  );

  bk_slot_sequencer #(
    .SLOT_BITS (2), .SECT_BITS (2), .LBA_W (32), .LBA_BASE (32'd1000), .TO_BITS (4)
  ) dut_b (
    .clk_sys (clk_sys), .reset (reset), .ena (ena_b), .load_req (load_req_b),
    .save_req (save_req_b), .slot (slot_b), .sd_lba (sd_lba_b), .sd_rd (sd_rd_b),
    .sd_wr (sd_wr_b), .sd_ack (sd_ack_b), .sect (sect_b), .busy (busy_b),
    .loading (loading_b), .done (done_b), .err (err_b)
  );

  typedef struct {
    int          kind;   // 0 request, 1 done, 2 err
    bit          wr;
    logic [31:0] lba;
    int          sct;
    bit          first;
  } ev_t;

  ev_t evq[2][$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  resp_en[2]   = '{1'b1, 1'b1};
  bit  resp_busy[2] = '{1'b0, 1'b0};
  bit  prev_req[2]  = '{1'b0, 1'b0};
  bit  prev_ack[2]  = '{1'b0, 1'b0};
  int  ack_age[2]   = '{100, 100};
  int  since_req[2] = '{100, 100};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: one request per sector at base + slot*sectors + i, then a done.
  task automatic push_run(input int w, input bit wr, input int base, input int slot_n,
                          input int nsect);
    ev_t e;
    for (int i = 0; i < nsect; i++) begin
      e.kind = 0; e.wr = wr; e.lba = 32'(base + slot_n * nsect + i); e.sct = i;
      e.first = (i == 0);
      evq[w].push_back(e);
    end
    e.kind = 1; e.wr = wr; e.lba = '0; e.sct = 0; e.first = 1'b0;
    evq[w].push_back(e);
  endtask

  task automatic push_err(input int w, input bit wr, input int lba);
    ev_t e;
    e.kind = 0; e.wr = wr; e.lba = 32'(lba); e.sct = 0; e.first = 1'b1;
    evq[w].push_back(e);
    e.kind = 2; e.first = 1'b0;
    evq[w].push_back(e);
  endtask

  task automatic mon_step(input int w, input logic rd, input logic wr, input logic [31:0] lba,
                          input int sct, input logic bsy, input logic ldg, input logic dn,
                          input logic er, input logic ack);
    ev_t   e;
    string p = (w == 0) ? "a" : "b";
    if (prev_ack[w] && !ack) ack_age[w] = 0;
    else if (ack_age[w] < 100) ack_age[w]++;
    if ((rd || wr) && !prev_req[w]) begin
      since_req[w] = 0;
      if (evq[w].size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_unexpected_req: actual lba %0d sect %0d required none", p, lba, sct);
      end else begin
        e = evq[w].pop_front();
        check({p, "_req_kind"}, 64'(0), 64'(e.kind));
        check({p, "_req_rdwr"}, {rd, wr}, e.wr ? 64'd1 : 64'd2);
        check({p, "_req_lba"}, lba, e.lba);
        check({p, "_req_sect"}, 64'(sct), 64'(e.sct));
        check({p, "_req_loading"}, ldg, !e.wr);
        check({p, "_req_busy"}, bsy, 1);
        if (!e.first) check({p, "_req_latency"}, 64'(ack_age[w]), 2);
      end
    end else if (since_req[w] < 100) begin
      since_req[w]++;
    end
    prev_req[w] = rd || wr;
    prev_ack[w] = ack;
    if (dn || er) begin
      if (evq[w].size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_unexpected_pulse: actual done %0d err %0d required none", p, dn, er);
      end else begin
        e = evq[w].pop_front();
        check({p, "_pulse_kind"}, dn ? 64'd1 : 64'd2, 64'(e.kind));
        check({p, "_pulse_busy"}, bsy, 0);
        check({p, "_pulse_loading"}, ldg, 0);
        check({p, "_pulse_rdwr"}, {rd, wr}, 0);
        if (dn) check({p, "_done_latency"}, 64'(ack_age[w]), 2);
        else    check({p, "_err_delay"}, 64'(since_req[w]), 15);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_req  = '{1'b0, 1'b0};
        prev_ack  = '{sd_ack, sd_ack_b};
        ack_age   = '{100, 100};
        since_req = '{100, 100};
      end else begin
        mon_step(0, sd_rd, sd_wr, sd_lba, int'(sect), busy, loading, done, err, sd_ack);
        mon_step(1, sd_rd_b, sd_wr_b, sd_lba_b, int'(sect_b), busy_b, loading_b, done_b, err_b,
                 sd_ack_b);
      end
    end
  end

  // hps_io models: ack a pending request after a short delay, hold it, release.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (resp_en[0] && (sd_rd || sd_wr) && !sd_ack && !reset) begin
        resp_busy[0] = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        repeat ($urandom_range(3, 10)) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
        resp_busy[0] = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (resp_en[1] && (sd_rd_b || sd_wr_b) && !sd_ack_b && !reset) begin
        resp_busy[1] = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk_sys);
        #1 sd_ack_b = 1'b1;
        repeat ($urandom_range(3, 8)) @(posedge clk_sys);
        #1 sd_ack_b = 1'b0;
        resp_busy[1] = 1'b0;
      end
    end
  end

  task automatic pulse(input int w, input bit ld, input bit sv);
    @(posedge clk_sys);
    #1;
    if (w == 0) begin load_req = ld; save_req = sv; end
    else begin load_req_b = ld; save_req_b = sv; end
    repeat (3) @(posedge clk_sys);
    #1;
    if (w == 0) begin load_req = 1'b0; save_req = 1'b0; end
    else begin load_req_b = 1'b0; save_req_b = 1'b0; end
  endtask

  task automatic wait_idle(input int w, input int budget);
    int n = 0;
    while (n < budget && (evq[w].size() != 0 || ((w == 0) ? busy : busy_b) ||
                          resp_busy[w] || ((w == 0) ? sd_ack : sd_ack_b))) begin
      @(negedge clk_sys);
      n++;
    end
    check((w == 0) ? "a_wait_in_budget" : "b_wait_in_budget", n < budget, 1);
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (4) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check("rst_a_rdwr", {sd_rd, sd_wr}, 0);
    check("rst_a_busy_loading", {busy, loading}, 0);
    check("rst_a_done_err", {done, err}, 0);
    check("rst_a_sect", sect, 0);
    check("rst_a_lba", sd_lba, 0);
    check("rst_b_lba", sd_lba_b, 1000);
    check("rst_b_state", {sd_rd_b, sd_wr_b, busy_b, done_b, err_b}, 0);

    // Load from slot 2 with default geometry
    slot = 2'd2;
    push_run(0, 1'b0, 0, 2, 64);
    pulse(0, 1'b1, 1'b0);
    wait_idle(0, 5000);

    // Save while unmounted does nothing; a fresh edge after mounting runs
    ena = 1'b0;
    slot = 2'd0;
    pulse(0, 1'b0, 1'b1);
    repeat (20) @(negedge clk_sys);
    check("ena0_busy", busy, 0);
    check("ena0_wr", sd_wr, 0);
    ena = 1'b1;
    repeat (3) @(posedge clk_sys);
    push_run(0, 1'b1, 0, 0, 64);
    pulse(0, 1'b0, 1'b1);
    wait_idle(0, 5000);

    // Simultaneous edges: load wins; a later save edge mid-run is dropped
    slot = 2'd1;
    push_run(0, 1'b0, 0, 1, 64);
    pulse(0, 1'b1, 1'b1);
    n = 0;
    while (n < 2000 && sect < 6'd10) begin @(negedge clk_sys); n++; end
    check("mid_run_reached", n < 2000, 1);
    pulse(0, 1'b0, 1'b1);
    wait_idle(0, 5000);

    // Reset in the middle of a save, then a clean load
    slot = 2'd0;
    push_run(0, 1'b1, 0, 0, 64);
    pulse(0, 1'b0, 1'b1);
    n = 0;
    while (n < 2000 && !(sd_wr && sect == 6'd5)) begin @(negedge clk_sys); n++; end
    check("sector5_reached", n < 2000, 1);
    @(posedge clk_sys);
    #1 reset = 1'b1;
    evq[0].delete();
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("midrst_rdwr", {sd_rd, sd_wr}, 0);
    check("midrst_busy_loading", {busy, loading}, 0);
    check("midrst_sect", sect, 0);
    check("midrst_lba", sd_lba, 0);
    check("midrst_done_err", {done, err}, 0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    wait_idle(0, 200);
    slot = 2'd3;
    push_run(0, 1'b0, 0, 3, 64);
    pulse(0, 1'b1, 1'b0);
    wait_idle(0, 5000);

    // Watchdog on instance b: no ack at all
    resp_en[1] = 1'b0;
    slot_b = 2'd0;
    push_err(1, 1'b0, 1000);
    pulse(1, 1'b1, 1'b0);
    wait_idle(1, 200);
    repeat (20) @(negedge clk_sys);
    resp_en[1] = 1'b1;

    // Small slot with LBA offset: 1012..1015
    slot_b = 2'd3;
    push_run(1, 1'b1, 1000, 3, 4);
    pulse(1, 1'b0, 1'b1);
    wait_idle(1, 500);

    // Random operations on both instances
    for (int r = 0; r < 3; r++) begin
      bit op_wr;
      int s;
      op_wr = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      slot = 2'(s);
      push_run(0, op_wr, 0, s, 64);
      pulse(0, !op_wr, op_wr);
      wait_idle(0, 5000);
      op_wr = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 3);
      slot_b = 2'(s);
      push_run(1, op_wr, 1000, s, 4);
      pulse(1, !op_wr, op_wr);
      wait_idle(1, 500);
    end

    check("a_queue_empty", 64'(evq[0].size()), 0);
    check("b_queue_empty", 64'(evq[1].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_slot_sequencer.md
# bk_slot_sequencer

Parametrised save-slot sequencer that moves a backup-RAM image between the core and the SD image in whole sectors. It turns load/save menu requests into a run of sd_rd/sd_wr requests over a contiguous LBA range. It generalises the core's fixed four-slot, 64-sector save logic with:
- configurable slot count and sectors per slot;
- a start LBA offset;
- an ack watchdog;
- done/error reporting.

It sits between hps_io's SD interface and the system's backup-RAM port.

## Interface
Parameters:
- SLOT_BITS, 2, slot number width (2^SLOT_BITS slots)
- SECT_BITS, 6, sectors-per-slot width (2^SECT_BITS × 512 B per slot)
- LBA_W, 32, sd_lba width
- LBA_BASE, 0, LBA of slot 0 sector 0
- TO_BITS, 24, ack watchdog width; timeout = 2^TO_BITS−1 cycles

Ports:
- clk_sys  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high reset
- ena  in  1  save image mounted and writable; gates requests
- load_req  in  1  level from status; rising edge starts a load
- save_req  in  1  level from status; rising edge starts a save
- slot  in  SLOT_BITS  slot select, sampled at start
- sd_lba  out  LBA_W  current sector LBA
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  hps_io transfer acknowledge
- sect  out  SECT_BITS  current sector index, used as backup-RAM address MSBs
- busy  out  1  operation in progress
- loading  out  1  load in progress; used to hold the system in reset
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on watchdog abort

## Operation
Request detection:
- Registered copies of (load_req & ena), (save_req & ena) and sd_ack are kept every cycle.
- A start event is a rising edge of a gated request.
- Start events are accepted only in IDLE; edges seen while busy are discarded, not queued.
- If load and save edges arrive in the same cycle, load wins.

States:
- **IDLE:** on a start event:
  - latch op (load = 1);
  - set sect = 0 and sd_lba = LBA_BASE + {slot, SECT_BITS'0}, zero-extended to LBA_W;
  - assert sd_rd (load) or sd_wr (save);
  - go to REQ.
- **REQ:** on an sd_ack rising edge (sd_ack=1, old_ack=0):
  - clear sd_rd and sd_wr;
  - go to XFER.
- **XFER:** on an sd_ack falling edge:
  - if sect is all ones, go to IDLE and pulse done;
  - otherwise increment sect and sd_lba, re-assert the same request, and go to REQ.
- **Watchdog:**
  - counter cleared on entry to REQ and on every sd_ack edge;
  - increments in REQ and XFER;
  - at all ones: clear sd_rd/sd_wr, go to IDLE, pulse err. No done pulse follows.

Status outputs:
- busy = (state != IDLE).
- loading = busy & op.
- ena falling mid-operation does not abort the operation.

Arithmetic:
- sd_lba increment is modulo 2^LBA_W.
- sect wrap never occurs, because the last sector exits to IDLE.

## Timing
- Reset values:
  - outputs: sd_rd=0, sd_wr=0, busy=0, loading=0, done=0, err=0, sect=0, sd_lba=LBA_BASE;
  - internal: edge registers 0, state IDLE, watchdog 0.
- Reset mid-transfer drops sd_rd/sd_wr on the next edge; the partial transfer is abandoned.
- Request edge sampled at edge n: busy, loading and sd_rd/sd_wr high after edge n+1 (one-cycle edge-detect latency).
- sd_ack first sampled high at edge m: sd_rd/sd_wr low after edge m+1.
- sd_ack first sampled low at edge k: new sd_lba/sect and request valid after edge k+1.
- Last sector: busy/loading low and done high after edge k+1; done is high for exactly one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package bk_pkg holds:
  - state enum (IDLE, REQ, XFER);
  - op encoding;
  - SECTOR_BYTES = 512.
- One sub-module, bk_ack_watchdog (TO_BITS counter with clear/enable/expire), instantiated once.
- Everything else stays in one always block.

## Test plan
- **Load, defaults:** ena=1, slot=2, load_req rises; a model acks each request after 3 cycles and holds ack for 10 cycles.
  - Exactly 64 sd_rd pulses at LBA 128..191, sect 0..63.
  - loading high throughout.
  - One done pulse; sd_wr never asserted.
- **Save with ena=0, then ena=1:**
  - No activity while ena=0.
  - After ena=1, a fresh save_req edge gives 64 sd_wr requests at LBA 0..63 and done.
- **Load and save edges in the same cycle, slot 1:**
  - Load runs at LBA 64..127; loading=1.
  - A second save edge mid-run is ignored; exactly 64 requests total.
- **Watchdog, TO_BITS=4:** sd_ack held low.
  - sd_rd drops and err pulses 15 cycles after REQ entry.
  - busy=0 and no done pulse.
- **Reset at sector 5 of a save:**
  - All outputs return to reset values after one edge.
  - A subsequent load starts at sect 0.
- **LBA_BASE=1000, SECT_BITS=2, slot=3:**
  - Requests at LBA 1012..1015.
  - done after the 4th ack fall.
